// File: rtl/rot_seq_8bit.sv
// rot_seq_8bit
//
// Multi-step rotate sequencer. It loads a byte and sends it once per clock
// through an external single-step 8-bit rotate stage for a programmed number
// of steps (0-7). It then returns the final byte with a one-cycle done pulse.
// The result is a rotate-by-N function that keeps the combinational stage
// single-step.
//
// Ports:
//   clk        sole clock, rising edge
//   rst_n      asynchronous active-low reset
//   start      request, sampled only in IDLE
//   din[7:0]   byte to rotate, captured with start
//   lr         direction captured with start (0 = left, 1 = right)
//   amount[2:0] number of single-step rotations, captured with start
//   rot_a[7:0] working byte driven to the rotate stage
//   rot_lr     latched direction driven to the rotate stage
//   rot_y[7:0] single-step result from the rotate stage (same cycle)
//   dout[7:0]  final byte, held until the next accepted start
//   busy       high while an operation is in flight (RUN and DONE)
//   done       one-cycle pulse, dout valid while high
//   state_dbg  current FSM state encoding (00 IDLE, 01 RUN, 10 DONE)
//
// Request/response protocol: an operation is accepted on any rising edge
// where start=1 and busy=0, so busy acts as the inverse of ready. The
// operands din/lr/amount matter only on that accepting edge. start while
// busy=1 is dropped, not queued. done marks a single-cycle response, and
// dout keeps its value after done falls.

module rot_seq_8bit (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] din,
    input  logic       lr,
    input  logic [2:0] amount,
    output logic [7:0] rot_a,
    output logic       rot_lr,
    input  logic [7:0] rot_y,
    output logic [7:0] dout,
    output logic       busy,
    output logic       done,
    output logic [1:0] state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    state_t     state, state_nxt;
    logic [7:0] cur, cur_nxt;
    logic [2:0] cnt, cnt_nxt;
    logic       dir_q, dir_nxt;
    logic       load_dout;

    // Next-state and datapath update.
    always_comb begin
        state_nxt = S_IDLE;
        cur_nxt   = cur;
        cnt_nxt   = cnt;
        dir_nxt   = dir_q;
        case (state)
            S_IDLE: begin
                state_nxt = S_IDLE;
                if (start) begin
                    cur_nxt   = din;
                    cnt_nxt   = amount;
                    dir_nxt   = lr;
                    // amount=0 skips RUN entirely, so done follows the accept edge
                    state_nxt = (amount != 3'd0) ? S_RUN : S_DONE;
                end
            end
            S_RUN: begin
                cur_nxt   = rot_y;
                cnt_nxt   = cnt - 3'd1;
                state_nxt = (cnt == 3'd1) ? S_DONE : S_RUN;
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                // Unused encoding 2'b11 falls back to IDLE.
                state_nxt = S_IDLE;
            end
        endcase
    end

    // dout takes the byte that cur is about to hold. It is therefore valid
    // in the same cycle that done goes high, for both the RUN path and the
    // amount=0 path.
    assign load_dout = (state_nxt == S_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cur   <= 8'h00;
            cnt   <= 3'd0;
            dir_q <= 1'b0;
            dout  <= 8'h00;
        end else begin
            state <= state_nxt;
            cur   <= cur_nxt;
            cnt   <= cnt_nxt;
            dir_q <= dir_nxt;
            if (load_dout) begin
                dout <= cur_nxt;
            end
        end
    end

    assign rot_a     = cur;
    assign rot_lr    = dir_q;
    assign busy      = (state == S_RUN) || (state == S_DONE);
    assign done      = (state == S_DONE);
    assign state_dbg = state;

endmodule
